// File: rtl/usb_rx_phy_if.sv
// Raw FS line pair into the receive front-end and its decoded byte/framing stream out.
interface usb_rx_phy_if;
  logic       usb_d_p;
  logic       usb_d_n;
  logic       rx_active;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_eop;
  logic       rx_error;
  logic       bus_reset;

  modport master (
    input  usb_d_p, usb_d_n,
    output rx_active, rx_byte, rx_byte_valid, rx_eop, rx_error, bus_reset
  );

  modport slave (
    output usb_d_p, usb_d_n,
    input  rx_active, rx_byte, rx_byte_valid, rx_eop, rx_error, bus_reset
  );
endinterface

// File: rtl/usb_rx_phy.sv
// FS USB receive front-end: sync, DPLL, NRZI, SYNC/unstuff/byte assembly, EOP and bus reset.
// Strobes fire 1 cycle after the deciding sample point; no backpressure, the stream is free-running.
module usb_rx_phy #(
  parameter int SE0_RESET_CYCLES  = 120,
  parameter int IDLE_RECOVER_BITS = 8
) (
  input  logic         clock48,
  input  logic         reset,
  usb_rx_phy_if.master phy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERR_WAIT
  } state_t;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam int SE0_W  = $clog2(SE0_RESET_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_RECOVER_BITS + 1);

  logic [1:0]        p_sync, n_sync;
  logic [1:0]        line, line_d;
  logic [1:0]        phase, phase_eff;
  logic              is_jk, jk_edge, sample, bit_val;
  logic [SE0_W-1:0]  se0_cnt;
  logic              bus_reset_c;

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [2:0]        ones_cnt, ones_n;
  logic [6:0]        shreg, shreg_n;
  logic [1:0]        prev_level, prev_n;
  logic              partial, partial_n;
  logic              se0_seen, se0_seen_n;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
  logic              err_c, eop_c, byte_c;

  logic              rx_active_q, rx_active_n;
  logic [7:0]        rx_byte_q;
  logic              byte_vld_q, byte_vld_n;
  logic              eop_q, eop_n;
  logic              err_q, err_n;

  // Synchronisers park at J so reset release never looks like a J->K start.
  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      p_sync <= 2'b11;
      n_sync <= 2'b00;
      line_d <= LS_J;
    end else begin
      p_sync <= {p_sync[0], phy.usb_d_p};
      n_sync <= {n_sync[0], phy.usb_d_n};
      line_d <= line;
    end
  end

  assign line      = {p_sync[1], n_sync[1]};
  assign is_jk     = (line == LS_J) || (line == LS_K);
  assign jk_edge   = is_jk && (line != line_d);
  assign phase_eff = jk_edge ? 2'd0 : phase;
  assign sample    = (phase_eff == 2'd2);
  assign bit_val   = (line == prev_level);

  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      phase   <= 2'd0;
      se0_cnt <= '0;
    end else begin
      phase <= phase_eff + 2'd1;
      if (line != LS_SE0)
        se0_cnt <= '0;
      else if (se0_cnt != SE0_W'(SE0_RESET_CYCLES))
        se0_cnt <= se0_cnt + 1'b1;
    end
  end

  assign bus_reset_c = (se0_cnt == SE0_W'(SE0_RESET_CYCLES)) && (line == LS_SE0);

  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      ones_cnt   <= 3'd0;
      shreg      <= 7'd0;
      prev_level <= LS_J;
      partial    <= 1'b0;
      se0_seen   <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      ones_cnt   <= ones_n;
      shreg      <= shreg_n;
      prev_level <= prev_n;
      partial    <= partial_n;
      se0_seen   <= se0_seen_n;
      idle_cnt   <= idle_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    ones_n     = ones_cnt;
    shreg_n    = shreg;
    prev_n     = prev_level;
    partial_n  = partial;
    se0_seen_n = se0_seen;
    idle_cnt_n = idle_cnt;
    err_c      = 1'b0;
    eop_c      = 1'b0;
    byte_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (line_d == LS_J && line == LS_K) begin
          state_n   = ST_SYNC;
          prev_n    = LS_J;
          bit_cnt_n = 3'd0;
        end
      end

      ST_SYNC: begin
        if (sample) begin
          if (!is_jk) begin
            err_c   = 1'b1;
            state_n = ST_ERR_WAIT;
          end else begin
            prev_n = line;
            // Seven zeros then a single one closes the SYNC.
            if (bit_val != (bit_cnt == 3'd7)) begin
              err_c   = 1'b1;
              state_n = ST_ERR_WAIT;
            end else if (bit_cnt == 3'd7) begin
              state_n   = ST_DATA;
              bit_cnt_n = 3'd0;
              ones_n    = 3'd0;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
      end

      ST_DATA: begin
        if (sample) begin
          if (line == LS_SE0) begin
            state_n    = ST_EOP;
            partial_n  = (bit_cnt != 3'd0);
            se0_seen_n = 1'b0;
          end else if (line == LS_SE1) begin
            err_c   = 1'b1;
            state_n = ST_ERR_WAIT;
          end else begin
            prev_n = line;
            if (ones_cnt == 3'd6) begin
              if (bit_val) begin
                err_c   = 1'b1;
                state_n = ST_ERR_WAIT;
              end else begin
                ones_n = 3'd0;
              end
            end else begin
              ones_n    = bit_val ? ones_cnt + 3'd1 : 3'd0;
              shreg_n   = {bit_val, shreg[6:1]};
              bit_cnt_n = bit_cnt + 3'd1;
              byte_c    = (bit_cnt == 3'd7);
            end
          end
        end
      end

      ST_EOP: begin
        if (sample) begin
          if (!se0_seen) begin
            if (line == LS_SE0) begin
              se0_seen_n = 1'b1;
            end else begin
              err_c   = 1'b1;
              state_n = ST_ERR_WAIT;
            end
          end else if (line == LS_J) begin
            err_c   = partial;
            eop_c   = !partial;
            state_n = ST_IDLE;
          end else if (line != LS_SE0) begin
            err_c   = 1'b1;
            state_n = ST_ERR_WAIT;
          end
        end
      end

      ST_ERR_WAIT: begin
        if (sample) begin
          case (line)
            LS_J: begin
              if (se0_seen || idle_cnt == IDLE_W'(IDLE_RECOVER_BITS - 1))
                state_n = ST_IDLE;
              else
                idle_cnt_n = idle_cnt + 1'b1;
            end
            LS_SE0: begin
              se0_seen_n = 1'b1;
              idle_cnt_n = '0;
            end
            default: begin
              se0_seen_n = 1'b0;
              idle_cnt_n = '0;
            end
          endcase
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_ERR_WAIT && state != ST_ERR_WAIT) begin
      idle_cnt_n = '0;
      se0_seen_n = 1'b0;
    end

    if (bus_reset_c)
      state_n = ST_IDLE;
  end

  // A bus reset swallows any strobe; otherwise error beats EOP beats byte.
  always_comb begin
    rx_active_n = (state_n == ST_DATA) || (state_n == ST_EOP);
    err_n       = 1'b0;
    eop_n       = 1'b0;
    byte_vld_n  = 1'b0;
    if (!bus_reset_c) begin
      if (err_c)
        err_n = 1'b1;
      else if (eop_c)
        eop_n = 1'b1;
      else if (byte_c)
        byte_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      rx_active_q <= 1'b0;
      rx_byte_q   <= 8'd0;
      byte_vld_q  <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_active_q <= rx_active_n;
      byte_vld_q  <= byte_vld_n;
      eop_q       <= eop_n;
      err_q       <= err_n;
      if (byte_vld_n)
        rx_byte_q <= {bit_val, shreg};
    end
  end

  assign phy.rx_active     = rx_active_q;
  assign phy.rx_byte       = rx_byte_q;
  assign phy.rx_byte_valid = byte_vld_q;
  assign phy.rx_eop        = eop_q;
  assign phy.rx_error      = err_q;
  assign phy.bus_reset     = bus_reset_c;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Randomised packet bench for usb_rx_phy with a symbol-level USB line model and scoreboard.
module tb_usb_rx_phy;

  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;
  localparam int M_NONE = 0, M_BYTE = 1, M_EOP = 2, M_ERR = 3, M_BR = 4, M_BRJ = 5;
  // Wire symbol start -> strobe: 2 sync flops, sample 2 cycles into the bit, 1 output register.
  localparam int LAT = 5;

  logic clock48 = 1'b0;
  logic reset;
  int   cyc = 0;

  usb_rx_phy_if phy();

  usb_rx_phy dut (
    .clock48 (clock48),
    .reset   (reset),
    .phy     (phy)
  );

  always #10 clock48 = ~clock48;
  always @(posedge clock48) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, want, want, cyc);
    end
  endtask

  // Line model: symbol queue with per-symbol duration and the event the symbol's sample must produce.
  logic [1:0] sym_q[$];
  int         dur_q[$];
  int         mark_q[$];
  logic [7:0] val_q[$];
  logic [1:0] tx_lvl = J;
  int         ones = 0;

  int         exp_byte_cyc[$];
  logic [7:0] exp_byte_val[$];
  int         exp_eop_cyc[$];
  int         exp_err_cyc[$];
  int         got_byte_cyc[$];
  logic [7:0] got_byte_val[$];
  int         got_eop_cyc[$];
  int         got_err_cyc[$];

  int br_start, brj_start;
  int br_rise = -1, br_fall = -1;
  bit br_prev = 1'b0;
  int br_act = 0, act_at_err = 0, excl_viol = 0;
  bit act_seen = 1'b0;

  always @(negedge clock48) begin
    if (phy.rx_byte_valid) begin
      got_byte_cyc.push_back(cyc);
      got_byte_val.push_back(phy.rx_byte);
    end
    if (phy.rx_eop) got_eop_cyc.push_back(cyc);
    if (phy.rx_error) begin
      got_err_cyc.push_back(cyc);
      if (phy.rx_active) act_at_err++;
    end
    if (int'(phy.rx_byte_valid) + int'(phy.rx_eop) + int'(phy.rx_error) > 1) excl_viol++;
    if (phy.rx_active) act_seen = 1'b1;
    if (phy.bus_reset && !br_prev) br_rise = cyc;
    if (!phy.bus_reset && br_prev) br_fall = cyc;
    if (phy.bus_reset && br_prev && phy.rx_active) br_act++;
    br_prev = phy.bus_reset;
  end

  task automatic set_line(input logic [1:0] l);
    phy.usb_d_p = l[1];
    phy.usb_d_n = l[0];
  endtask

  task automatic add_sym(input logic [1:0] l, input int d, input int m, input logic [7:0] v);
    sym_q.push_back(l);
    dur_q.push_back(d);
    mark_q.push_back(m);
    val_q.push_back(v);
  endtask

  // NRZI: a 0 toggles the line, a 1 keeps it.
  task automatic add_bit(input bit b, input int m, input logic [7:0] v);
    if (!b) tx_lvl = (tx_lvl == J) ? K : J;
    add_sym(tx_lvl, 4, m, v);
  endtask

  task automatic add_idle(input int n);
    tx_lvl = J;
    for (int i = 0; i < n; i++) add_sym(J, 4, M_NONE, 8'h00);
  endtask

  task automatic add_sync(input bit good);
    tx_lvl = J;
    ones   = 0;
    for (int i = 0; i < 7; i++) add_bit(1'b0, M_NONE, 8'h00);
    if (good) add_bit(1'b1, M_NONE, 8'h00);
    else      add_bit(1'b0, M_ERR, 8'h00);
  endtask

  // LSB-first data bits with a stuffed 0 after every six consecutive 1s.
  task automatic add_bits(input logic [7:0] v, input int n, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      add_bit(v[i], (mark_last && i == n - 1) ? M_BYTE : M_NONE, v);
      ones = v[i] ? ones + 1 : 0;
      if (ones == 6) begin
        add_bit(1'b0, M_NONE, 8'h00);
        ones = 0;
      end
    end
  endtask

  task automatic add_eop(input bit partial);
    add_sym(SE0, 4, M_NONE, 8'h00);
    add_sym(SE0, 4, M_NONE, 8'h00);
    add_sym(J, 4, partial ? M_ERR : M_EOP, 8'h00);
    tx_lvl = J;
  endtask

  task automatic send();
    while (sym_q.size() > 0) begin
      logic [1:0] l;
      int d, m, st;
      logic [7:0] v;
      l = sym_q.pop_front();
      d = dur_q.pop_front();
      m = mark_q.pop_front();
      v = val_q.pop_front();
      set_line(l);
      st = cyc;
      case (m)
        M_BYTE: begin exp_byte_cyc.push_back(st + LAT); exp_byte_val.push_back(v); end
        M_EOP:  exp_eop_cyc.push_back(st + LAT);
        M_ERR:  exp_err_cyc.push_back(st + LAT);
        M_BR:   br_start = st;
        M_BRJ:  brj_start = st;
        default: ;
      endcase
      repeat (d) @(posedge clock48);
      #1;
    end
  endtask

  task automatic clear_got();
    got_byte_cyc.delete(); got_byte_val.delete(); got_eop_cyc.delete(); got_err_cyc.delete();
  endtask

  task automatic compare(input string tag, input bit timed);
    check({tag, ".nbytes"}, got_byte_cyc.size(), exp_byte_cyc.size());
    for (int i = 0; i < got_byte_cyc.size() && i < exp_byte_cyc.size(); i++) begin
      check({tag, ".byte"}, got_byte_val[i], exp_byte_val[i]);
      if (timed) check({tag, ".byte_cyc"}, got_byte_cyc[i], exp_byte_cyc[i]);
    end
    check({tag, ".neop"}, got_eop_cyc.size(), exp_eop_cyc.size());
    for (int i = 0; timed && i < got_eop_cyc.size() && i < exp_eop_cyc.size(); i++)
      check({tag, ".eop_cyc"}, got_eop_cyc[i], exp_eop_cyc[i]);
    check({tag, ".nerr"}, got_err_cyc.size(), exp_err_cyc.size());
    for (int i = 0; timed && i < got_err_cyc.size() && i < exp_err_cyc.size(); i++)
      check({tag, ".err_cyc"}, got_err_cyc[i], exp_err_cyc[i]);
    exp_byte_cyc.delete(); exp_byte_val.delete(); exp_eop_cyc.delete(); exp_err_cyc.delete();
    clear_got();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".rx_active"}, phy.rx_active, 0);
    check({tag, ".rx_byte"}, phy.rx_byte, 0);
    check({tag, ".rx_byte_valid"}, phy.rx_byte_valid, 0);
    check({tag, ".rx_eop"}, phy.rx_eop, 0);
    check({tag, ".rx_error"}, phy.rx_error, 0);
    check({tag, ".bus_reset"}, phy.bus_reset, 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 200000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset = 1'b1;
    set_line(J);
    repeat (3) @(posedge clock48);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (4) @(posedge clock48);
    #1;
    clear_got();

    // Basic packet: one byte 0x2D.
    act_seen = 1'b0;
    add_idle(4); add_sync(1'b1); add_bits(8'h2D, 8, 1'b1); add_eop(1'b0); add_idle(10);
    send();
    compare("pkt2d", 1'b1);
    check("pkt2d.active_seen", act_seen, 1);

    // Two 0xFF bytes exercise stuffing across the byte boundary.
    add_idle(2); add_sync(1'b1); add_bits(8'hFF, 8, 1'b1); add_bits(8'hFF, 8, 1'b1);
    add_eop(1'b0); add_idle(10);
    send();
    compare("ffff", 1'b1);

    // Seven 1s without a stuff bit, 8 J bit times of recovery, then a good packet.
    act_at_err = 0;
    add_idle(2); add_sync(1'b1);
    for (int i = 0; i < 6; i++) add_bit(1'b1, M_NONE, 8'h00);
    add_bit(1'b1, M_ERR, 8'h00);
    add_idle(8);
    add_sync(1'b1); add_bits(8'hC3, 8, 1'b1); add_eop(1'b0); add_idle(10);
    send();
    compare("stufferr", 1'b1);
    check("stufferr.active_at_err", act_at_err, 0);

    // SYNC ending KJ.
    act_seen = 1'b0;
    add_idle(2); add_sync(1'b0); add_idle(12);
    send();
    compare("badsync", 1'b1);
    check("badsync.active_seen", act_seen, 0);

    // SE1 in the middle of data.
    act_at_err = 0;
    add_idle(2); add_sync(1'b1); add_bits(8'h69, 8, 1'b1); add_sym(SE1, 4, M_ERR, 8'h00);
    add_idle(12);
    send();
    compare("se1", 1'b1);
    check("se1.active_at_err", act_at_err, 0);

    // EOP with a partial byte pending.
    add_idle(2); add_sync(1'b1); add_bits(8'h3C, 8, 1'b1); add_bits(8'h05, 3, 1'b0);
    add_eop(1'b1); add_idle(10);
    send();
    compare("partial", 1'b1);

    // SE0 held 130 cycles mid-packet.
    br_act = 0; br_rise = -1; br_fall = -1;
    add_idle(2); add_sync(1'b1); add_bits(8'hA5, 8, 1'b1); add_bits(8'h05, 3, 1'b0);
    add_sym(SE0, 130, M_BR, 8'h00);
    add_sym(J, 4, M_BRJ, 8'h00);
    tx_lvl = J;
    add_idle(10);
    send();
    compare("busrst", 1'b1);
    check("busrst.rise", br_rise, br_start + 2 + 120);
    check("busrst.fall", br_fall, brj_start + 2);
    check("busrst.active", br_act, 0);

    // Random packets, some ending with a partial byte.
    for (int p = 0; p < 12; p++) begin
      int nb;
      nb = $urandom_range(1, 6);
      add_idle(3);
      add_sync(1'b1);
      for (int b = 0; b < nb; b++)
        add_bits(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)), 8, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        add_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7), 1'b0);
        add_eop(1'b1);
      end else begin
        add_eop(1'b0);
      end
    end
    add_idle(10);
    send();
    compare("rand", 1'b1);

    // Bit-time drift: alternating 3- and 5-cycle bits through SYNC and data.
    add_idle(3);
    base = sym_q.size();
    add_sync(1'b1); add_bits(8'h2D, 8, 1'b1);
    for (int i = base; i < sym_q.size(); i++) begin
      if ((i - base) % 8 == 3) dur_q[i] = 3;
      if ((i - base) % 8 == 7) dur_q[i] = 5;
    end
    add_eop(1'b0); add_idle(10);
    send();
    compare("drift", 1'b0);

    // Reset in the middle of a byte, then quiet line, then a fresh packet.
    add_idle(2); add_sync(1'b1); add_bits(8'h5A, 4, 1'b0);
    send();
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    set_line(J);
    repeat (3) @(posedge clock48);
    #1;
    reset = 1'b0;
    clear_got();
    add_idle(20);
    send();
    compare("quiet", 1'b1);
    add_sync(1'b1); add_bits(8'h96, 8, 1'b1); add_eop(1'b0); add_idle(10);
    send();
    compare("afterrst", 1'b1);

    check("strobe_exclusive", excl_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_phy.md
Name: usb_rx_phy

Overview:
- Receive front-end for the full-speed USB device port, clocked by clock48 at 4x the 12 Mb/s bit rate.
- Synchronises usb_d_p/usb_d_n and recovers bit timing with a simple DPLL.
- Performs NRZI decoding, SYNC detection, bit unstuffing, byte assembly and EOP/bus-reset detection.
- Feeds the packet receiver downstream with a byte stream plus packet-framing strobes, replacing raw line sampling there.

Parameters:
- SE0_RESET_CYCLES, 120: consecutive SE0 cycles (2.5 us at 48 MHz) that constitute a bus reset.
- IDLE_RECOVER_BITS, 8: consecutive J bit times required to leave error recovery.

Ports:
- clock48  input  1  48 MHz clock
- reset  input  1  asynchronous, active-high reset
- usb_d_p  input  1  raw D+ line
- usb_d_n  input  1  raw D- line
- rx_active  output  1  high from end of valid SYNC until EOP, error or bus reset
- rx_byte  output  8  received byte, LSB = first bit on the wire
- rx_byte_valid  output  1  one-cycle strobe; rx_byte valid this cycle
- rx_eop  output  1  one-cycle strobe on a clean end of packet
- rx_error  output  1  one-cycle strobe on SYNC, stuffing, framing or SE1 error
- bus_reset  output  1  high while SE0 has persisted ≥ SE0_RESET_CYCLES

Behaviour:
- Reset: async, active-high. Clears all outputs to 0, puts state in IDLE, clears the SE0 counter, sets the DPLL phase to 0 and prev_level to J.
- Input path: 2-flop synchroniser on each line. Decoded line states: J (p=1, n=0), K (p=0, n=1), SE0 (0,0), SE1 (1,1).
- DPLL: 2-bit phase counter.
  - Forced to 0 on any J/K change of the synchronised line; otherwise increments mod 4.
  - Sample point is phase == 2.
  - Bit period is nominally 4 cycles; 3- or 5-cycle bits are tolerated.
- NRZI: at each sample point, decoded bit = 1 if the level equals prev_level, else 0. prev_level then takes the sampled level.
- States:
  - IDLE: wait for a J→K transition, then go to SYNC with prev_level = J and bit count = 0.
  - SYNC: collect 8 decoded bits.
    - Sequence must be 0,0,0,0,0,0,0,1 (KJKJKJKK). On match: go to DATA and set rx_active = 1 the cycle after the 8th sample point.
    - Any mismatch, SE0 or SE1: pulse rx_error and go to ERROR_WAIT.
  - DATA:
    - Ones counter: increments on each decoded 1 and clears on each 0.
    - Stuff bit: when the counter reaches 6, the next decoded bit must be 0. That bit is discarded and the counter cleared. If it is 1: pulse rx_error, go to ERROR_WAIT.
    - Byte assembly: non-stuffed bits shift in LSB-first. After 8 bits, rx_byte is loaded and rx_byte_valid pulses for one cycle, exactly 1 cycle after the 8th bit's sample point. The bit counter wraps to 0.
    - SE0 at a sample point goes to EOP. If the bit counter is nonzero, the partial byte is discarded and rx_error pulses instead of rx_eop at EOP completion.
    - SE1 at a sample point: pulse rx_error, go to ERROR_WAIT.
  - EOP: require SE0 at the next sample point, then J at the following sample point.
    - On J: pulse rx_eop (or rx_error per above), drop rx_active in the same cycle, go to IDLE.
    - K or SE1 at either sample point: pulse rx_error, go to ERROR_WAIT.
  - ERROR_WAIT: rx_active = 0. Return to IDLE after IDLE_RECOVER_BITS consecutive J sample points, or after an SE0-then-J sequence.
- rx_active low in every state except DATA and EOP. rx_byte holds its last value when not strobed.
- Bus reset: SE0 counter runs in all states.
  - Counts synchronised SE0 cycles, clears on any non-SE0 cycle, saturates at SE0_RESET_CYCLES.
  - bus_reset = 1 while counter == SE0_RESET_CYCLES and the line is still SE0.
  - Reaching the threshold forces IDLE and clears rx_active. No rx_eop or rx_error is pulsed.
- Strobes are mutually exclusive within a cycle. Priority: bus reset > rx_error > rx_eop > rx_byte_valid.

Test Plan:
- SYNC, then byte 0x2D, then SE0,SE0,J at 4 cycles/bit → rx_active high; one rx_byte_valid with rx_byte = 0x2D; one rx_eop; rx_error never high.
- SYNC, then 0xFF,0xFF with a stuffed 0 after each run of six 1s, then EOP → exactly two strobes, both 0xFF; rx_eop once.
- SYNC, then seven consecutive 1s (no stuffed bit) → rx_error pulse at the 7th bit's sample point + 1; rx_active low; no rx_eop; after 8 J bit times a new valid packet is received correctly.
- Corrupt SYNC ending KJ instead of KK → rx_error once; no rx_byte_valid; rx_active never asserts.
- SE0 held 130 cycles mid-packet → bus_reset rises 120 cycles after the synchronised SE0 start and falls when J returns; rx_active is 0; no rx_eop.
- Drift: same as the first test but every 8th bit stretched to 5 cycles and another shortened to 3 → 0x2D received correctly; also assert reset mid-byte → all outputs 0 immediately, with no strobe after reset release until a new SYNC.
